// File: rtl/if_id_queue_pkg.sv
// Shared constants and entry layout for the fetch-to-decode queue.
package if_id_queue_pkg;

  localparam int PC_W  = 32;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] IFQ_NOP_INST = 32'h00000000;
  localparam logic [PC_W-1:0]   IFQ_RESET_PC = 32'h00010000;

  typedef struct packed {
    logic [PC_W-1:0]   pc4;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_regfile.sv
// Queue storage: one synchronous write port, one asynchronous read port.
module ifq_regfile
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ifq_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output ifq_entry_t    rdata
);

  ifq_entry_t mem [DEPTH];

  // No reset: contents are only observable through a valid head entry.
  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID buffer: small circular FIFO with valid/ready on both sides and flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                  DEPTH    = 2,
  parameter logic [INST_W-1:0]   NOP_INST = IFQ_NOP_INST
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [PC_W-1:0]          IN_PC4,
  input  logic [INST_W-1:0]        IN_INST,
  input  logic                     FLUSH,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [PC_W-1:0]          OUT_PC4,
  output logic [INST_W-1:0]        OUT_INST,
  output logic [$clog2(DEPTH):0]   OCC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          full, empty, push, pop;
  ifq_entry_t    wr_entry, rd_entry;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Ready is purely registered so fetch's PC stall never sees a pop-credit loop.
  assign IN_READY  = !full;
  assign OUT_VALID = !empty;

  assign push = IN_VALID  & IN_READY  & !FLUSH;
  assign pop  = OUT_VALID & OUT_READY & !FLUSH;

  assign wr_entry.pc4  = IN_PC4;
  assign wr_entry.inst = IN_INST;

  ifq_regfile #(.DEPTH(DEPTH), .AW(AW)) u_regfile (
    .clk_sys (CLOCK),
    .we      (push),
    .waddr   (wp),
    .wdata   (wr_entry),
    .raddr   (rp),
    .rdata   (rd_entry)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (FLUSH) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign OUT_PC4  = empty ? '0       : rd_entry.pc4;
  assign OUT_INST = empty ? NOP_INST : rd_entry.inst;
  assign OCC      = cnt;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: model-predicted state checks plus an output scoreboard.
module tb_if_id_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000000;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_PC4 = '0;
  logic [31:0] IN_INST = '0;
  logic        FLUSH = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_PC4;
  logic [31:0] OUT_INST;
  logic [$clog2(DEPTH):0] OCC;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;
  logic [63:0] exp_q [$];

  if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_PC4    (IN_PC4),
    .IN_INST   (IN_INST),
    .FLUSH     (FLUSH),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_PC4   (OUT_PC4),
    .OUT_INST  (OUT_INST),
    .OCC       (OCC)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " occ"},       32'(OCC),       32'(mcnt));
    chk({tag, " in_ready"},  32'(IN_READY),  32'(mcnt < DEPTH));
    chk({tag, " out_valid"}, 32'(OUT_VALID), 32'(mcnt > 0));
    if (mcnt == 0) begin
      chk({tag, " nop_inst"}, OUT_INST, NOP);
      chk({tag, " nop_pc4"},  OUT_PC4,  32'h0);
    end
  endtask

  // Drive one cycle of stimulus, predict the handshake, advance past the edge, check.
  task automatic cycle(input string tag, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy, input logic fl);
    logic m_push, m_pop;
    IN_VALID  = iv;
    IN_PC4    = pc;
    IN_INST   = inst;
    OUT_READY = ordy;
    FLUSH     = fl;
    m_push = iv && (mcnt < DEPTH) && !fl;
    m_pop  = ordy && (mcnt > 0) && !fl;
    if (fl) exp_q.delete();
    else if (m_push) exp_q.push_back({pc, inst});
    @(posedge CLOCK);
    #1;
    if (fl) mcnt = 0;
    else mcnt = mcnt + int'(m_push) - int'(m_pop);
    check_state(tag);
  endtask

  // Monitor: an accepted head entry must match the oldest expected word.
  always @(negedge CLOCK) begin
    if (RESET && OUT_VALID && OUT_READY && !FLUSH) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pc4=%h inst=%h expected none", OUT_PC4, OUT_INST);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("out_pc4",  OUT_PC4,  e[63:32]);
        chk("out_inst", OUT_INST, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset occ",       32'(OCC),       32'h0);
    chk("reset in_ready",  32'(IN_READY),  32'h1);
    chk("reset out_valid", 32'(OUT_VALID), 32'h0);
    chk("reset out_inst",  OUT_INST,       NOP);
    RESET = 1'b1;
    @(posedge CLOCK); #1;

    // Single pass with ID stalled.
    cycle("single_push", 1'b1, 32'h00010004, 32'h20080005, 1'b0, 1'b0);
    chk("single out_pc4", OUT_PC4, 32'h00010004);
    cycle("single_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stall fill, refused third word, then in-order drain.
    cycle("fill0", 1'b1, 32'h00010004, 32'h11110001, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 32'h00010008, 32'h11110002, 1'b0, 1'b0);
    cycle("fill_refuse", 1'b1, 32'h0001000C, 32'h11110003, 1'b0, 1'b0);
    chk("full head pc4", OUT_PC4, 32'h00010004);
    cycle("drain0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain head pc4", OUT_PC4, 32'h00010008);
    cycle("drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming: 10 words with both sides always ready.
    for (int k = 0; k < 10; k++)
      cycle("stream", 1'b1, 32'h00010004 + 32'(4 * k), 32'h20080000 + 32'(k), 1'b1, 1'b0);
    cycle("stream_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush dominates a simultaneous push and pop.
    cycle("pre_flush0", 1'b1, 32'h00020004, 32'h33330001, 1'b0, 1'b0);
    cycle("pre_flush1", 1'b1, 32'h00020008, 32'h33330002, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'hDEAD0004, 32'hDEADBEEF, 1'b1, 1'b1);
    cycle("post_flush", 1'b1, 32'h00030004, 32'h44440001, 1'b1, 1'b0);
    cycle("post_flush_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Empty pops are no-ops.
    for (int k = 0; k < 3; k++)
      cycle("empty_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with two entries held.
    cycle("pre_rst0", 1'b1, 32'h00040004, 32'h55550001, 1'b0, 1'b0);
    cycle("pre_rst1", 1'b1, 32'h00040008, 32'h55550002, 1'b0, 1'b0);
    IN_VALID = 1'b0;
    #2;
    RESET = 1'b0;
    #1;
    exp_q.delete();
    mcnt = 0;
    chk("async_rst occ",       32'(OCC),       32'h0);
    chk("async_rst in_ready",  32'(IN_READY),  32'h1);
    chk("async_rst out_valid", 32'(OUT_VALID), 32'h0);
    chk("async_rst out_inst",  OUT_INST,       NOP);
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    cycle("after_rst", 1'b1, 32'h00050004, 32'h66660001, 1'b1, 1'b0);
    cycle("after_rst_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
